// File: rtl/timing_nco.sv
// Modulo-1 NCO timing controller: issues one interpolation strobe and fractional interval per symbol.
// Latency: one register stage from sample_valid to interpolator_en/f; no backpressure (enable freezes state).
module timing_nco #(
  parameter int          SPS_LOG2  = 1,
  parameter logic [15:0] W_NOM     = 16'h8000,
  parameter int          ERR_SHIFT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               sample_valid,
  input  logic signed [15:0] loop_err,
  input  logic               loop_err_valid,
  output logic               interpolator_en,
  output logic [15:0]        f,
  output logic [15:0]        symbol_cnt
);

  localparam logic signed [17:0] W_MIN = {3'b000, W_NOM[15:1]};
  localparam logic signed [17:0] W_MAX = {2'b00, W_NOM} + W_MIN;

  logic [15:0]             eta;
  logic [15:0]             w;
  logic signed [15:0]      err_sh;
  logic signed [17:0]      w_sum;
  logic [15:0]             w_next;
  logic [16+SPS_LOG2:0]    f_wide;
  logic [15:0]             f_sat;
  logic                    underflow;

  assign err_sh = loop_err >>> ERR_SHIFT;
  assign w_sum  = $signed({2'b00, W_NOM}) + $signed({{2{err_sh[15]}}, err_sh});

  always_comb begin
    w_next = w_sum[15:0];
    if (w_sum < W_MIN)
      w_next = W_MIN[15:0];
    else if (w_sum > W_MAX)
      w_next = W_MAX[15:0];
  end

  // eta/W approximated by eta * samples-per-symbol, saturated into Q0.16
  assign f_wide    = {{(SPS_LOG2+1){1'b0}}, eta} << SPS_LOG2;
  assign f_sat     = (|f_wide[16+SPS_LOG2:16]) ? 16'hFFFF : f_wide[15:0];
  assign underflow = (eta < w);

  always_ff @(posedge clk) begin
    if (reset) begin
      eta             <= 16'hFFFF;
      w               <= W_NOM;
      f               <= 16'h0000;
      symbol_cnt      <= 16'h0000;
      interpolator_en <= 1'b0;
    end else begin
      interpolator_en <= 1'b0;
      if (enable) begin
        if (loop_err_valid)
          w <= w_next;
        // step uses the W held before this edge, even when W is updated now
        if (sample_valid) begin
          eta <= eta - w;
          if (underflow) begin
            f               <= f_sat;
            interpolator_en <= 1'b1;
            symbol_cnt      <= symbol_cnt + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_timing_nco.sv
// Bench for timing_nco: two instances (default and zero error shift) checked cycle by cycle against an arithmetic model.
module tb_timing_nco;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               sample_valid;
  logic signed [15:0] loop_err;
  logic               loop_err_valid;
  logic               en_a, en_b;
  logic [15:0]        f_a, f_b, cnt_a, cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  // model state, index 0 = ERR_SHIFT 4, index 1 = ERR_SHIFT 0
  int m_eta[2], m_w[2], m_f[2], m_cnt[2], m_en[2];
  int sh[2] = '{4, 0};

  always #5 clk = ~clk;

  timing_nco dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .loop_err(loop_err), .loop_err_valid(loop_err_valid),
    .interpolator_en(en_a), .f(f_a), .symbol_cnt(cnt_a)
  );

  timing_nco #(.ERR_SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .loop_err(loop_err), .loop_err_valid(loop_err_valid),
    .interpolator_en(en_b), .f(f_b), .symbol_cnt(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input bit sv, input bit lev, input int err);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_eta[k] = 65535; m_w[k] = 32768; m_f[k] = 0; m_cnt[k] = 0; m_en[k] = 0;
      end else begin
        int nw;
        m_en[k] = 0;
        nw = m_w[k];
        if (en) begin
          if (lev) begin
            nw = 32768 + (err >>> sh[k]);
            if (nw < 16384) nw = 16384;
            if (nw > 49152) nw = 49152;
          end
          if (sv) begin
            if (m_eta[k] < m_w[k]) begin
              m_f[k]   = (m_eta[k] * 2 > 65535) ? 65535 : m_eta[k] * 2;
              m_en[k]  = 1;
              m_cnt[k] = (m_cnt[k] + 1) % 65536;
            end
            m_eta[k] = (m_eta[k] - m_w[k] + 65536) % 65536;
          end
        end
        m_w[k] = nw;
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit en, input bit sv, input bit lev, input logic [15:0] err);
    reset = rst; enable = en; sample_valid = sv; loop_err_valid = lev; loop_err = err;
    @(posedge clk);
    #1;
    model_step(rst, en, sv, lev, int'($signed(err)));
    check("en_s4",  {31'd0, en_a}, m_en[0]);
    check("f_s4",   {16'd0, f_a},  m_f[0]);
    check("cnt_s4", {16'd0, cnt_a}, m_cnt[0]);
    check("eta_s4", {16'd0, dut.eta}, m_eta[0]);
    check("en_s0",  {31'd0, en_b}, m_en[1]);
    check("f_s0",   {16'd0, f_b},  m_f[1]);
    check("cnt_s0", {16'd0, cnt_b}, m_cnt[1]);
    check("eta_s0", {16'd0, dut0.eta}, m_eta[1]);
  endtask

  initial begin
    int guard;
    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; loop_err_valid = 1'b0; loop_err = '0;

    // reset with other inputs active, then nominal cadence
    cycle(1, 1, 1, 1, 16'h1234);
    cycle(1, 0, 0, 0, 16'h0000);
    for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0, 16'h0000);

    // positive error: W = 8100 on the default instance
    cycle(1, 0, 0, 0, 16'h0000);
    cycle(0, 1, 0, 1, 16'h1000);
    for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0, 16'h0000);

    // clamp on the zero-shift instance: C000 then 4000
    cycle(0, 1, 0, 1, 16'h7FFF);
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, 0, 16'h0000);
    cycle(0, 1, 0, 1, 16'h8000);
    for (int i = 0; i < 14; i++) cycle(0, 1, 1, 0, 16'h0000);

    // freeze: samples and error words arrive but must be ignored
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 1, 16'(($urandom)));
    // gapped input
    cycle(0, 1, 0, 1, 16'h0000);
    for (int i = 0; i < 10; i++) cycle(0, 1, (i % 2) == 0, 0, 16'h0000);

    // simultaneous error update and sample
    cycle(0, 1, 1, 1, 16'h1000);
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 16'h0000);

    // reset on the cycle an underflow would occur
    guard = 0;
    while (m_eta[0] >= m_w[0] && guard < 8) begin
      cycle(0, 1, 1, 0, 16'h0000);
      guard++;
    end
    check("underflow_reached", {31'd0, (m_eta[0] < m_w[0])}, 32'd1);
    cycle(1, 1, 1, 0, 16'h0000);
    for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, 16'h0000);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(63) == 0, $urandom_range(7) != 0, $urandom_range(3) != 0,
            $urandom_range(7) == 0, 16'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timing_nco.md
# timing_nco

Modulo-1 NCO timing controller for the Gardner symbol timing recovery loop. It consumes the input sample stream cadence and the loop-filter output. Once per symbol it produces the interpolation strobe (`interpolator_en`) and the fractional interval `f`, which drive the interpolator. It is the control/initiator end of the interpolator's `interpolator_en`/`f` interface and sits between the loop filter and the interpolator.

## Interface
- `SPS_LOG2`, default 1: log2 of samples per symbol; nominal 2 samples/symbol.
- `W_NOM`, default 16'h8000: nominal NCO decrement, Q0.16, equal to 2^(16-SPS_LOG2).
- `ERR_SHIFT`, default 4: arithmetic right shift applied to `loop_err` before it is added to `W_NOM`.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: when low, the NCO freezes; `eta`, `W`, `f` and the counter hold and no strobes are issued.
- `sample_valid` in 1: one input sample is present this cycle; the NCO advances once per asserted cycle.
- `loop_err` in 16 signed: loop-filter output, Q1.15.
- `loop_err_valid` in 1: `loop_err` is valid this cycle.
- `interpolator_en` out 1: one-cycle strobe meaning "interpolate now".
- `f` out 16: fractional interval mu, unsigned Q0.16; updated only with the strobe.
- `symbol_cnt` out 16: number of strobes issued; wraps modulo 2^16.

## Operation
- Registers:
  - `eta`: 16-bit unsigned NCO phase, modulo 1.
  - `W`: 16-bit control word.
  - `f`, `symbol_cnt`, `interpolator_en`.
- Control word update, on a cycle with `loop_err_valid`=1 and `enable`=1:
  - `W <= clamp(W_NOM + (loop_err >>> ERR_SHIFT), W_NOM/2, W_NOM + W_NOM/2)`.
  - The sum is computed at 18 bits signed, then clamped.
- NCO step, on a cycle with `sample_valid`=1 and `enable`=1:
  - `underflow = (eta < W)`, using the `W` held before this edge.
  - `eta <= (eta - W) mod 2^16`.
  - If `underflow`:
    - `f <= sat16(eta << SPS_LOG2)`, computed at 17+ bits and saturated to 16'hFFFF. This is the eta/W approximation for W ≈ W_NOM.
    - `interpolator_en <= 1` and `symbol_cnt <= symbol_cnt + 1`.
- `interpolator_en` is 0 on every cycle that is not a registered underflow.
- Simultaneous `loop_err_valid` and `sample_valid`: the NCO step uses the old `W`; the new `W` applies from the next sample.
- `loop_err_valid` while `enable`=0 is ignored.
- Operating modes:
  - FREEZE (`enable`=0): registers hold.
  - TRACK (`enable`=1): normal operation.
  - Leaving FREEZE resumes from the held `eta`; there is no re-initialisation.

## Timing
- Reset values (applied on the first edge with `reset`=1, regardless of other inputs):
  - `eta` = 16'hFFFF
  - `W` = `W_NOM`
  - `f` = 16'h0000
  - `symbol_cnt` = 0
  - `interpolator_en` = 0
- Reset asserted mid-symbol discards any pending strobe. The first `sample_valid` after reset release is processed normally.
- Latency: `sample_valid` at edge n gives `interpolator_en` and the new `f` valid after edge n+1, i.e. one register stage.
- `f` changes only on the edge that raises `interpolator_en`, and holds until the next strobe.
- `loop_err` accepted at edge n affects the `underflow` decision for samples at edge n+1 onward.
- Strobe spacing: strobes are at least 1 and at most 4 samples apart; this follows from the clamp range.
- `interpolator_en` never asserts on consecutive cycles unless `sample_valid` is asserted on consecutive cycles.
- `symbol_cnt` wraps from 16'hFFFF to 16'h0000 with no flag.

## Test plan
- **Reset and nominal cadence.** `reset` for 2 cycles, then `enable`=1, `sample_valid`=1 continuously, `loop_err`=0.
  - Strobe on every 2nd sample; `f`=16'hFFFE on each strobe.
  - `eta` alternates 16'h7FFF / 16'hFFFF; `symbol_cnt` increments by 1 per strobe.
- **Positive error tracking.** `loop_err`=16'h1000 with `loop_err_valid` pulsed once, giving `W`=16'h8100.
  - `eta` sequence: FFFF → 7EFF → FDFF (strobe, `f`=FDFE) → 7CFF → FBFF (strobe, `f`=F9FE).
  - `f` decreases by 16'h0400 per symbol.
- **Clamp.** With `ERR_SHIFT`=0: `loop_err`=16'h7FFF gives `W`=16'hC000; `loop_err`=16'h8000 gives `W`=16'h4000.
  - With `W`=16'h4000, strobes are 4 samples apart.
  - With `W`=16'hC000, `f` saturates to 16'hFFFF whenever `eta` ≥ 16'h8000 at underflow.
- **Freeze and gapped input.**
  - `enable`=0 for 10 cycles with `sample_valid`=1 and `loop_err_valid`=1: no strobes, `eta`/`W`/`f`/`symbol_cnt` unchanged.
  - `sample_valid` toggling 1-0-1-0: strobes land only on valid cycles, every 2nd valid sample.
- **Simultaneous events.** `loop_err_valid` and `sample_valid` on the same cycle: the step uses the old `W` (check `eta` value), and the next sample uses the new `W`.
- **Reset mid-operation.** Assert `reset` on the cycle an underflow would occur.
  - No strobe is issued; all outputs return to their reset values.
  - Cadence restarts with a strobe on the 2nd post-reset sample.
